// File: rtl/hrfp_mult_arbiter_pkg.sv
// Shared widths and helpers for the HRFP multiplier arbiter.
// The operand width follows `MSBBIT from the HRFP definitions when that header is present.
`ifndef MSBBIT
`define MSBBIT 31
`endif

package hrfp_mult_arbiter_pkg;

  localparam int OP_W = `MSBBIT + 1;

  // A single requester still needs a one-bit id field.
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/hrfp_rr_arbiter.sv
// Rotating-priority grant: scans from the pointer upward with wrap-around and returns a
// one-hot grant, its index and the pointer value that follows that grant.
module hrfp_rr_arbiter
  import hrfp_mult_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] i_elig,
  input  logic [ID_W-1:0]    i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic               o_any,
  output logic [ID_W-1:0]    o_idx,
  output logic [ID_W-1:0]    o_ptr_nxt
);

  logic [ID_W-1:0] w_cand;

  always_comb begin
    o_grant   = '0;
    o_any     = 1'b0;
    o_idx     = '0;
    o_ptr_nxt = i_ptr;
    w_cand    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_cand = ID_W'((int'(i_ptr) + k) % NUM_REQ);
      if (!o_any && i_elig[w_cand]) begin
        o_any           = 1'b1;
        o_idx           = w_cand;
        o_grant[w_cand] = 1'b1;
        o_ptr_nxt       = ID_W'((int'(w_cand) + 1) % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/hrfp_mult_arbiter.sv
// Round-robin front end for one shared, fixed-latency HRFP multiplier; the requester id rides
// a tag pipeline aligned with the datapath so each result comes back tagged with its origin.
module hrfp_mult_arbiter
  import hrfp_mult_arbiter_pkg::*;
#(
  parameter int  NUM_REQ  = 4,
  parameter int  MULT_LAT = 8,
  parameter int  MAX_OUT  = 3,
  localparam int ID_W     = id_width(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*OP_W-1:0]   req_op_a,
  input  logic [NUM_REQ*OP_W-1:0]   req_op_b,
  output logic [OP_W-1:0]           mult_op_a,
  output logic [OP_W-1:0]           mult_op_b,
  input  logic [OP_W-1:0]           mult_result,
  output logic                      res_valid,
  output logic [ID_W-1:0]           res_id,
  output logic [OP_W-1:0]           res_data,
  output logic                      busy
);

  localparam int CNT_W = $clog2(MAX_OUT + 1);
  // One stage mirrors the operand register, the remaining MULT_LAT mirror the datapath.
  localparam int NSTG  = MULT_LAT + 1;

  logic [NUM_REQ-1:0] w_elig;
  logic [NUM_REQ-1:0] w_grant;
  logic [NUM_REQ-1:0] w_ret;
  logic               w_any;
  logic               w_fire;
  logic [ID_W-1:0]    w_gnt_idx;
  logic [ID_W-1:0]    w_ptr_nxt;

  logic [ID_W-1:0]    r_ptr;
  logic [OP_W-1:0]    r_op_a;
  logic [OP_W-1:0]    r_op_b;
  logic [CNT_W-1:0]   r_cnt [NUM_REQ];
  logic [NSTG-1:0]    r_tag_vld_p;
  logic [ID_W-1:0]    r_tag_id_p [NSTG];

  function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cnt,
                                                input logic inc, input logic dec);
    case ({inc, dec})
      2'b10:   return cnt + 1'b1;
      2'b01:   return cnt - 1'b1;
      default: return cnt;
    endcase
  endfunction

  // A requester at its credit limit may still issue when one of its results retires now.
  always_comb begin
    w_ret  = '0;
    w_elig = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_ret[i]  = r_tag_vld_p[NSTG-1] && (r_tag_id_p[NSTG-1] == ID_W'(i));
      w_elig[i] = req_valid[i] && ((r_cnt[i] < CNT_W'(MAX_OUT)) || w_ret[i]);
    end
  end

  hrfp_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr (
    .i_elig    (w_elig),
    .i_ptr     (r_ptr),
    .o_grant   (w_grant),
    .o_any     (w_any),
    .o_idx     (w_gnt_idx),
    .o_ptr_nxt (w_ptr_nxt)
  );

  assign w_fire    = w_any && rst_n;
  assign req_ready = rst_n ? w_grant : '0;

  // Issue stage: operands and tag head load on the grant edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr       <= '0;
      r_op_a      <= '0;
      r_op_b      <= '0;
      r_tag_vld_p <= '0;
    end else begin
      r_tag_vld_p <= {r_tag_vld_p[NSTG-2:0], w_fire};
      if (w_fire) begin
        r_ptr  <= w_ptr_nxt;
        r_op_a <= req_op_a[int'(w_gnt_idx)*OP_W +: OP_W];
        r_op_b <= req_op_b[int'(w_gnt_idx)*OP_W +: OP_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    r_tag_id_p[0] <= w_gnt_idx;
    for (int s = 1; s < NSTG; s++) begin
      r_tag_id_p[s] <= r_tag_id_p[s-1];
    end
  end

  // Credit stage: one outstanding counter per requester.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!rst_n) begin
        r_cnt[i] <= '0;
      end else begin
        r_cnt[i] <= cnt_next(r_cnt[i], w_fire && (w_gnt_idx == ID_W'(i)), w_ret[i]);
      end
    end
  end

  always @(posedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        assert (!(w_ret[i] && (r_cnt[i] == '0)));
        assert (!(w_fire && (w_gnt_idx == ID_W'(i)) && !w_ret[i] &&
                  (r_cnt[i] == CNT_W'(MAX_OUT))));
      end
    end
  end

  // Output stage: the tag tail lines up with the datapath result.
  assign mult_op_a = r_op_a;
  assign mult_op_b = r_op_b;
  assign res_valid = r_tag_vld_p[NSTG-1];
  assign res_id    = r_tag_id_p[NSTG-1];
  assign res_data  = mult_result;
  assign busy      = |r_tag_vld_p;

endmodule

// File: tb/tb_hrfp_mult_arbiter.sv
// Bench for hrfp_mult_arbiter: a fixed-latency integer multiplier stands in for the HRFP core
// and a scoreboard queue holds the tagged products in issue order.
module tb_hrfp_mult_arbiter;
  import hrfp_mult_arbiter_pkg::*;

  localparam int NUM_REQ  = 4;
  localparam int MULT_LAT = 8;
  localparam int MAX_OUT  = 3;
  localparam int ID_W     = id_width(NUM_REQ);

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ-1:0]      req_ready;
  logic [NUM_REQ*OP_W-1:0] req_op_a;
  logic [NUM_REQ*OP_W-1:0] req_op_b;
  logic [OP_W-1:0]         mult_op_a;
  logic [OP_W-1:0]         mult_op_b;
  logic [OP_W-1:0]         mult_result;
  logic                    res_valid;
  logic [ID_W-1:0]         res_id;
  logic [OP_W-1:0]         res_data;
  logic                    busy;

  typedef struct {
    logic [ID_W-1:0] id;
    logic [OP_W-1:0] data;
    int              cyc;
  } sb_t;

  sb_t sbq[$];
  int  n_vec   = 0;
  int  n_err   = 0;
  int  cyc     = 0;
  int  last_hs = -1;

  logic [OP_W-1:0] mpipe [MULT_LAT];

  hrfp_mult_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .MULT_LAT (MULT_LAT),
    .MAX_OUT  (MAX_OUT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op_a    (req_op_a),
    .req_op_b    (req_op_b),
    .mult_op_a   (mult_op_a),
    .mult_op_b   (mult_op_b),
    .mult_result (mult_result),
    .res_valid   (res_valid),
    .res_id      (res_id),
    .res_data    (res_data),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Shared multiplier model: product appears MULT_LAT cycles after the operand registers.
  always @(posedge clk) begin
    mpipe[0] <= mult_op_a * mult_op_b;
    for (int k = 1; k < MULT_LAT; k++) mpipe[k] <= mpipe[k-1];
  end
  assign mult_result = mpipe[MULT_LAT-1];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [OP_W-1:0] op_a_of(input int i);
    return req_op_a[i*OP_W +: OP_W];
  endfunction

  function automatic logic [OP_W-1:0] op_b_of(input int i);
    return req_op_b[i*OP_W +: OP_W];
  endfunction

  // Monitor: retire results against the queue first, then log this cycle's handshake.
  always @(negedge clk) begin
    sb_t e;
    if (!rst_n) begin
      sbq.delete();
    end else begin
      if (res_valid) begin
        if (sbq.size() == 0) begin
          chk("res_unexpected", 1, 0);
        end else begin
          e = sbq.pop_front();
          chk("res_id", res_id, e.id);
          chk("res_data", res_data, e.data);
          chk("res_cycle", cyc, e.cyc);
        end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          e.id   = ID_W'(i);
          e.data = op_a_of(i) * op_b_of(i);
          e.cyc  = cyc + 1 + MULT_LAT;
          sbq.push_back(e);
          last_hs = cyc;
        end
      end
      chk("ready_onehot", $onehot0(req_ready), 1);
      for (int i = 0; i < NUM_REQ; i++) chk("cnt_le_max", int'(dut.r_cnt[i]) <= MAX_OUT, 1);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [OP_W-1:0] a, input logic [OP_W-1:0] b);
    req_op_a[i*OP_W +: OP_W] = a;
    req_op_b[i*OP_W +: OP_W] = b;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic drain();
    int n = 0;
    while ((busy || sbq.size() != 0) && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk("drain_busy", busy, 0);
    chk("drain_sb_empty", sbq.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [NUM_REQ-1:0] exp_rdy;
    int n;
    req_valid = '0;
    req_op_a  = '0;
    req_op_b  = '0;

    // Reset state, with requests raised to show ready is held low.
    req_valid = '1;
    repeat (2) step();
    @(negedge clk);
    chk("rst_ready", req_ready, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_op_a", mult_op_a, 0);
    chk("rst_op_b", mult_op_b, 0);
    step();
    req_valid = '0;
    rst_n = 1'b1;

    // Single requester: 2 * 3 from requester 2.
    step();
    set_req(2, 2, 3);
    req_valid = 4'b0100;
    @(negedge clk);
    chk("single_ready", req_ready, 4'b0100);
    step();
    req_valid = '0;
    drain();

    // Fairness from reset with everybody requesting.
    do_reset();
    req_valid = '1;
    for (int k = 0; k < 16; k++) begin
      for (int i = 0; i < NUM_REQ; i++) set_req(i, $urandom, $urandom);
      exp_rdy = '0;
      exp_rdy[k % NUM_REQ] = 1'b1;
      @(negedge clk);
      chk("fair_grant", req_ready, exp_rdy);
      step();
    end
    req_valid = '0;
    drain();

    // Credit limit on requester 1.
    do_reset();
    req_valid = 4'b0010;
    for (int k = 0; k < 20; k++) begin
      set_req(1, $urandom, $urandom);
      @(negedge clk);
      chk("credit_ready1", req_ready[1], (k <= 2) || (k >= 9 && k <= 11) || (k >= 18));
      if (k == 5) chk("credit_cnt_full", dut.r_cnt[1], MAX_OUT);
      step();
    end
    req_valid = '0;
    drain();

    // Pointer wrap: park ptr at 3, then only requesters 0 and 2.
    do_reset();
    set_req(0, 5, 7);
    set_req(2, 11, 13);
    req_valid = 4'b0100;
    @(negedge clk);
    chk("wrap_pre", req_ready, 4'b0100);
    step();
    req_valid = 4'b0101;
    @(negedge clk);
    chk("wrap_g0", req_ready, 4'b0001);
    step();
    @(negedge clk);
    chk("wrap_g2", req_ready, 4'b0100);
    step();
    @(negedge clk);
    chk("wrap_g0b", req_ready, 4'b0001);
    step();
    req_valid = '0;
    drain();

    // Reset with three operations in flight.
    req_valid = 4'b1000;
    repeat (3) begin
      set_req(3, $urandom, $urandom);
      step();
    end
    req_valid = '0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int k = 0; k < MULT_LAT + 2; k++) begin
      @(negedge clk);
      chk("midrst_res_valid", res_valid, 0);
      chk("midrst_busy", busy, 0);
      step();
    end
    for (int i = 0; i < NUM_REQ; i++) chk("midrst_cnt", dut.r_cnt[i], 0);

    // Randomised mixed traffic.
    for (int k = 0; k < 10000; k++) begin
      req_valid = NUM_REQ'($urandom);
      for (int i = 0; i < NUM_REQ; i++) set_req(i, $urandom, $urandom);
      step();
    end
    req_valid = '0;
    n = 0;
    while (cyc < last_hs + 1 + MULT_LAT && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("busy_last_cycle", busy, 1);
    @(negedge clk);
    chk("busy_fall", busy, 0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
